// File: rtl/out_bcd.sv
// Output-register stage feeding the 7-segment driver: latches a bus word and
// converts it serially (double dabble) into packed BCD digits plus a sign flag.
module out_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LD,
  input  logic [WIDTH-1:0]      BUS,
  input  logic                  SIGNED,
  output logic [WIDTH-1:0]      VALUE,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  NEG,
  output logic                  BUSY,
  output logic                  VALID
);

  localparam int BW  = 4 * DIGITS;
  localparam int SRW = BW + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CONVERT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             neg_q, neg_d;
  logic             valid_q, valid_d;
  logic [SRW-1:0]   sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_bus_q, pend_bus_d;
  logic             pend_sgn_q, pend_sgn_d;

  logic [SRW-1:0]   adj;
  logic [SRW-1:0]   shifted;
  logic             start;
  logic [WIDTH-1:0] st_bus;
  logic             st_sgn;
  logic             st_neg;
  logic [WIDTH-1:0] st_mag;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the branches can leave it unassigned and infer a latch.
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[WIDTH+4*i +: 4] >= 4'd5) adj[WIDTH+4*i +: 4] = adj[WIDTH+4*i +: 4] + 4'd3;
    end
    shifted = adj << 1;
  end

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    valid_d    = 1'b0;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    pend_d     = pend_q;
    pend_bus_d = pend_bus_q;
    pend_sgn_d = pend_sgn_q;
    start      = 1'b0;
    st_bus     = BUS;
    st_sgn     = SIGNED;

    if (LD) value_d = BUS;

    case (state_q)
      IDLE: begin
        // Fresh LD data beats a pending load; either way the slot is consumed.
        if (LD) begin
          start  = 1'b1;
          pend_d = 1'b0;
        end else if (pend_q) begin
          start  = 1'b1;
          st_bus = pend_bus_q;
          st_sgn = pend_sgn_q;
          pend_d = 1'b0;
        end
      end
      CONVERT: begin
        if (LD) begin
          pend_d     = 1'b1;
          pend_bus_d = BUS;
          pend_sgn_d = SIGNED;
        end
        sr_d  = shifted;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = shifted[SRW-1 -: BW];
          neg_d   = sign_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    st_neg = st_sgn & st_bus[WIDTH-1];
    st_mag = st_neg ? (~st_bus) + WIDTH'(1) : st_bus;
    if (start) begin
      sr_d    = {{BW{1'b0}}, st_mag};
      cnt_d   = CW'(WIDTH);
      sign_d  = st_neg;
      state_d = CONVERT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the shift register and pending slot are reset too; an aborted
  // conversion must leave nothing behind that a later edge could pick up.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      value_q    <= '0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      valid_q    <= 1'b0;
      sr_q       <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_bus_q <= '0;
      pend_sgn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      valid_q    <= valid_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      pend_q     <= pend_d;
      pend_bus_q <= pend_bus_d;
      pend_sgn_q <= pend_sgn_d;
    end
  end

  assign VALUE = value_q;
  assign BCD   = bcd_q;
  assign NEG   = neg_q;
  assign BUSY  = (state_q == CONVERT);
  assign VALID = valid_q;

endmodule
